// File: rtl/user_io_spi_master.sv
// SPI master standing in for the board IO controller: streams button/switch and joystick
// command frames to the user_io slave and captures the core-type byte it returns on MISO.
module user_io_spi_master #(
    parameter int CLK_DIV = 25,
    parameter int GAP     = 64
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic [5:0] JOY0_IN,
    input  logic [5:0] JOY1_IN,
    input  logic [1:0] BUTTONS_IN,
    input  logic [1:0] SWITCHES_IN,
    input  logic       SPI_MISO,
    output logic       SPI_CLK,
    output logic       SPI_SS,
    output logic       SPI_MOSI,
    output logic [7:0] CORE_TYPE_RX,
    output logic       CORE_VALID,
    output logic       ROUND_DONE
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

    // Encoding {ss, clk_n, id}: SPI_SS and SPI_CLK come straight off state flops, glitch-free.
    typedef enum logic [3:0] {
        ST_SETUP = 4'b0000,
        ST_HIGH  = 4'b0001,
        ST_HOLD  = 4'b0010,
        ST_LOW   = 4'b0100,
        ST_IDLE  = 4'b1000,
        ST_GAP   = 4'b1001
    } state_t;

    state_t           state, state_nx;
    logic [DIV_W-1:0] div_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [3:0]       bit_cnt;
    logic [1:0]       cmd_idx;
    logic [15:0]      pins_p0, pins_p1;
    logic [15:0]      word_p0;
    logic [7:0]       rx_sh;
    logic             div_last, gap_last, hold_end;

    function automatic logic [15:0] frame_word(input logic [1:0] cmd, input logic [15:0] pins);
        case (cmd)
            2'd2:    frame_word = {8'h02, 2'b00, pins[5:0]};
            2'd3:    frame_word = {8'h03, 2'b00, pins[11:6]};
            default: frame_word = {8'h01, 4'h0, pins[15:14], pins[13:12]};
        endcase
    endfunction

    assign div_last = (div_cnt == DIV_LAST);
    assign gap_last = (gap_cnt == GAP_LAST);
    assign hold_end = (state == ST_HOLD) && div_last;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (ENABLE)   state_nx = ST_SETUP;
            ST_SETUP: if (div_last) state_nx = ST_LOW;
            ST_LOW:   if (div_last) state_nx = ST_HIGH;
            ST_HIGH:  if (div_last) state_nx = (bit_cnt == 4'd15) ? ST_HOLD : ST_LOW;
            ST_HOLD:  if (div_last) state_nx = ST_GAP;
            ST_GAP:   if (gap_last) state_nx = ST_IDLE;
            default:                state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        SPI_SS   = state[3];
        SPI_CLK  = ~state[2];
        SPI_MOSI = 1'b0;
        if (state == ST_LOW || state == ST_HIGH) SPI_MOSI = word_p0[~bit_cnt];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            div_cnt <= '0;
            gap_cnt <= '0;
            bit_cnt <= '0;
            cmd_idx <= 2'd1;
        end else begin
            if (state_nx != state || state == ST_IDLE || state == ST_GAP) div_cnt <= '0;
            else                                                          div_cnt <= div_cnt + 1'b1;
            gap_cnt <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
            // Wraps 15 -> 0 on the final HIGH, ready for the next frame.
            if (state == ST_HIGH && div_last) bit_cnt <= bit_cnt + 1'b1;
            if (hold_end) cmd_idx <= (cmd_idx == 2'd3) ? 2'd1 : cmd_idx + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            CORE_TYPE_RX <= 8'h00;
            CORE_VALID   <= 1'b0;
            ROUND_DONE   <= 1'b0;
        end else begin
            ROUND_DONE <= hold_end && (cmd_idx == 2'd3);
            if (hold_end && cmd_idx == 2'd1) begin
                CORE_TYPE_RX <= rx_sh;
                CORE_VALID   <= (rx_sh != 8'h00) && (rx_sh != 8'hFF);
            end
        end
    end

    // Input synchroniser, frame snapshot at SS fall, and MISO shift of the first byte.
    always_ff @(posedge CLK) begin
        pins_p0 <= {SWITCHES_IN, BUTTONS_IN, JOY1_IN, JOY0_IN};
        pins_p1 <= pins_p0;
        if (state == ST_IDLE && ENABLE) word_p0 <= frame_word(cmd_idx, pins_p1);
        if (state == ST_HIGH && div_last && !bit_cnt[3] && cmd_idx == 2'd1)
            rx_sh <= {rx_sh[6:0], SPI_MISO};
    end

endmodule
